// File: rtl/pm_arb_pkg.sv
// Shared types and constants for the program memory arbiter and its RAM.
package pm_arb_pkg;

    typedef enum logic {BOOT, RUN} state_e;

    typedef enum logic [1:0] {GNT_NONE, GNT_FETCH, GNT_LOAD} grant_e;

    localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TEXT_BASE = 32'h0040_0000;

endpackage

// File: rtl/program_ram.sv
// Synchronous single-port instruction store with a registered read port.
// The array has no reset so its contents survive an arbiter reset.
module program_ram
    import pm_arb_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int DW    = 32,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  logic [DW-1:0]    wdata,
    output logic [DW-1:0]    rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[idx] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/program_memory_arbiter.sv
// Shares the instruction store between CPU fetch and the boot/debug loader.
// Optional FAULT_TRAP_EN: range/alignment check with a sticky addr_fault flag.
module program_memory_arbiter
    import pm_arb_pkg::*;
#(
    parameter int                    MEMORY_DEPTH = 64,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = DEFAULT_TEXT_BASE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [DATA_WIDTH-1:0] fetch_addr,
    output logic                  fetch_valid,
    output logic [DATA_WIDTH-1:0] fetch_instr,
    output logic                  stall,
    input  logic                  load_req,
    input  logic [DATA_WIDTH-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ack,
    input  logic                  load_done,
    output logic                  addr_fault
);

    // state | meaning
    // BOOT  | CPU stalled, only the loader is granted; load_done moves to RUN
    // RUN   | fetch and loader arbitrated round-robin; left only by reset

    localparam int                    IDX_W   = $clog2(MEMORY_DEPTH);
    localparam logic [DATA_WIDTH-1:0] DEPTH_W = DATA_WIDTH'(MEMORY_DEPTH);

    state_e                  state_q, state_d;
    grant_e                  last_grant_q, last_grant_d, grant;
    logic                    fetch_valid_q, fetch_valid_d;
    logic                    load_ack_q, load_ack_d;
    logic                    fetch_nop_q, fetch_nop_d;
    logic [DATA_WIDTH-1:0]   fetch_off, load_off, ram_rdata;
    logic [IDX_W-1:0]        fetch_idx, load_idx, ram_idx;
    logic                    fetch_legal, load_legal;
    logic                    fetch_grant, load_grant, ram_we, ram_re;

    assign fetch_off = fetch_addr - TEXT_BASE;
    assign load_off  = load_addr - TEXT_BASE;
    assign fetch_idx = fetch_off[IDX_W+1:2];
    assign load_idx  = load_off[IDX_W+1:2];

`ifdef FAULT_TRAP_EN
    logic addr_fault_q, addr_fault_d;

    assign fetch_legal = (fetch_addr[1:0] == 2'b00) && (fetch_addr >= TEXT_BASE)
                         && ((fetch_off >> 2) < DEPTH_W);
    assign load_legal  = (load_addr[1:0] == 2'b00) && (load_addr >= TEXT_BASE)
                         && ((load_off >> 2) < DEPTH_W);

    always_comb begin
        addr_fault_d = addr_fault_q | (fetch_grant & ~fetch_legal) | (load_grant & ~load_legal);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_fault_q <= 1'b0;
        end else begin
            addr_fault_q <= addr_fault_d;
        end
    end

    assign addr_fault = addr_fault_q;
`else
    // Without the trap the index simply wraps; the discarded offset bits are intentional.
    logic unused_off_bits;

    assign fetch_legal     = 1'b1;
    assign load_legal      = 1'b1;
    assign unused_off_bits = ^{fetch_off[DATA_WIDTH-1:IDX_W+2], fetch_off[1:0],
                               load_off[DATA_WIDTH-1:IDX_W+2], load_off[1:0]};
    assign addr_fault      = 1'b0;
`endif

    always_comb begin
        grant = GNT_NONE;
        if (state_q == BOOT) begin
            if (load_req) grant = GNT_LOAD;
        end else if (fetch_req && load_req) begin
            grant = (last_grant_q == GNT_FETCH) ? GNT_LOAD : GNT_FETCH;
        end else if (fetch_req) begin
            grant = GNT_FETCH;
        end else if (load_req) begin
            grant = GNT_LOAD;
        end
    end

    assign fetch_grant = (grant == GNT_FETCH);
    assign load_grant  = (grant == GNT_LOAD);

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        fetch_valid_d = fetch_grant;
        load_ack_d    = load_grant;
        fetch_nop_d   = fetch_grant & ~fetch_legal;
        if (grant != GNT_NONE) last_grant_d = grant;
        if (state_q == BOOT && load_done) state_d = RUN;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= BOOT;
            last_grant_q  <= GNT_LOAD;
            fetch_valid_q <= 1'b0;
            load_ack_q    <= 1'b0;
            fetch_nop_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            fetch_valid_q <= fetch_valid_d;
            load_ack_q    <= load_ack_d;
            fetch_nop_q   <= fetch_nop_d;
        end
    end

    // Writes are gated by reset so a write racing a reset assertion is dropped.
    assign ram_we  = load_grant & load_legal & reset;
    assign ram_re  = fetch_grant & fetch_legal;
    assign ram_idx = fetch_grant ? fetch_idx : load_idx;

    program_ram #(
        .DEPTH (MEMORY_DEPTH),
        .DW    (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .idx   (ram_idx),
        .wdata (load_data),
        .rdata (ram_rdata)
    );

    assign fetch_valid = fetch_valid_q;
    assign load_ack    = load_ack_q;
    assign fetch_instr = (fetch_valid_q && !fetch_nop_q) ? ram_rdata : DATA_WIDTH'(NOP_INSTR);
    assign stall       = (state_q == BOOT) | (fetch_req & ~fetch_grant);

endmodule

// File: tb/tb_program_memory_arbiter.sv
// Scoreboard bench for program_memory_arbiter: a per-cycle reference model predicts
// grants and responses, a separate monitor matches fetch_valid/load_ack against them.
module tb_program_memory_arbiter;

    localparam logic [31:0] BASE  = 32'h0040_0000;
    localparam int          DEPTH = 64;
`ifdef FAULT_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0, reset = 1'b0;
    logic        fetch_req = 1'b0, load_req = 1'b0, load_done = 1'b0;
    logic [31:0] fetch_addr = '0, load_addr = '0, load_data = '0;
    logic        fetch_valid, stall, load_ack, addr_fault;
    logic [31:0] fetch_instr;

    program_memory_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .stall       (stall),
        .load_req    (load_req),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_ack    (load_ack),
        .load_done   (load_done),
        .addr_fault  (addr_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    exp_t        fq[$];
    exp_t        lq[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    logic [31:0] mem_m [DEPTH];
    bit          booted = 1'b0;
    bit          last_fetch = 1'b0;
    bit          fault_m = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, got, exp);
        end
    endtask

    function automatic int m_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'((off >> 2) % 32'd64);
    endfunction

    function automatic bit m_legal(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return (a[1:0] == 2'b00) && (a >= BASE) && ((off >> 2) < 32'd64);
    endfunction

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0:       return BASE + 32'h100 + 4 * $urandom_range(0, 63);
            1:       return BASE + $urandom_range(0, 255);
            2:       return BASE - 4 * $urandom_range(1, 4);
            default: return BASE + 4 * $urandom_range(0, 63);
        endcase
    endfunction

    // Called just after a rising edge; predicts this cycle's grant at the falling edge.
    task automatic step(input bit fr, input logic [31:0] fa, input bit lr,
                        input logic [31:0] la, input logic [31:0] ld, input bit done,
                        output bit fg, output bit lg);
        exp_t e;
        bit   bad;
        fetch_req  = fr;
        fetch_addr = fa;
        load_req   = lr;
        load_addr  = la;
        load_data  = ld;
        load_done  = done;
        @(negedge clk);
        fg = 1'b0;
        lg = 1'b0;
        if (!booted) begin
            lg = lr;
        end else if (fr && lr) begin
            fg = !last_fetch;
            lg = last_fetch;
        end else begin
            fg = fr;
            lg = lr;
        end
        check("stall", {31'b0, stall}, {31'b0, (!booted || (fr && !fg))});
        if (fg) begin
            bad = TRAP && !m_legal(fa);
            e.due  = cyc + 1;
            e.data = bad ? 32'h0 : mem_m[m_idx(fa)];
            if (bad) fault_m = 1'b1;
            e.fault = fault_m;
            fq.push_back(e);
            last_fetch = 1'b1;
        end
        if (lg) begin
            bad = TRAP && !m_legal(la);
            if (bad) fault_m = 1'b1;
            else     mem_m[m_idx(la)] = ld;
            e.due   = cyc + 1;
            e.data  = 32'h0;
            e.fault = fault_m;
            lq.push_back(e);
            last_fetch = 1'b0;
        end
        if (done) booted = 1'b1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (fetch_valid) begin
                if (fq.size() == 0 || fq[0].due != cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL fetch_valid unexpected at cycle %0d: got 1 expected 0", cyc);
                end else begin
                    e = fq.pop_front();
                    check("fetch_instr", fetch_instr, e.data);
                    check("addr_fault_fetch", {31'b0, addr_fault}, {31'b0, e.fault});
                end
            end else if (fq.size() != 0 && fq[0].due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL fetch_valid missing at cycle %0d: got 0 expected 1", cyc);
                void'(fq.pop_front());
            end
            if (load_ack) begin
                if (lq.size() == 0 || lq[0].due != cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL load_ack unexpected at cycle %0d: got 1 expected 0", cyc);
                end else begin
                    e = lq.pop_front();
                    check("addr_fault_load", {31'b0, addr_fault}, {31'b0, e.fault});
                end
            end else if (lq.size() != 0 && lq[0].due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL load_ack missing at cycle %0d: got 0 expected 1", cyc);
                void'(lq.pop_front());
            end
        end
    end

    task automatic run_random(input int n);
        bit          fr = 1'b0, lr = 1'b0, fg, lg;
        logic [31:0] fa = BASE, la = BASE, ld = '0;
        for (int i = 0; i < n; i++) begin
            if (!fr && $urandom_range(0, 3) != 0) begin
                fr = 1'b1;
                fa = rand_addr();
            end
            if (!lr && $urandom_range(0, 2) == 0) begin
                lr = 1'b1;
                la = rand_addr();
                ld = $urandom;
            end
            step(fr, fa, lr, la, ld, 1'b0, fg, lg);
            if (fg) fr = 1'b0;
            if (lg) lr = 1'b0;
        end
    endtask

    initial begin
        bit          fg, lg;
        logic [31:0] fa, la, ld;
        int          rb [5] = '{0, 1, 2, 9, 63};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_stall", {31'b0, stall}, 32'd1);
        check("reset_fetch_valid", {31'b0, fetch_valid}, 32'd0);
        check("reset_load_ack", {31'b0, load_ack}, 32'd0);
        check("reset_fetch_instr", fetch_instr, 32'h0);
        check("reset_addr_fault", {31'b0, addr_fault}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Boot fill with the CPU also requesting (must stay stalled).
        step(1'b1, BASE, 1'b1, BASE, 32'h2008_0005, 1'b0, fg, lg);
        step(1'b1, BASE, 1'b1, BASE + 4, 32'h0000_0000, 1'b0, fg, lg);
        for (int i = 2; i < DEPTH - 1; i++)
            step(1'($urandom_range(0, 1)), BASE, 1'b1, BASE + 4 * i, $urandom, 1'b0, fg, lg);
        // load_done coincident with the final granted load.
        step(1'b0, BASE, 1'b1, BASE + 4 * (DEPTH - 1), $urandom, 1'b1, fg, lg);
        step(1'b1, BASE, 1'b0, BASE, 32'h0, 1'b0, fg, lg);
        step(1'b1, BASE + 4 * (DEPTH - 1), 1'b0, BASE, 32'h0, 1'b0, fg, lg);
        step(1'b0, BASE, 1'b0, BASE, 32'h0, 1'b0, fg, lg);

        // Contention: a lone load first, then both held together.
        step(1'b0, BASE, 1'b1, BASE + 4 * 5, $urandom, 1'b0, fg, lg);
        fa = BASE + 8;
        la = BASE + 4 * 6;
        ld = $urandom;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, fa, 1'b1, la, ld, 1'b0, fg, lg);
            if (fg) fa = fa + 4;
            if (lg) begin
                la = la + 4;
                ld = $urandom;
            end
        end
        step(1'b0, BASE, 1'b0, BASE, 32'h0, 1'b0, fg, lg);

        // Misaligned and out-of-range accesses.
        step(1'b1, BASE + 2, 1'b0, BASE, 32'h0, 1'b0, fg, lg);
        step(1'b1, BASE + 32'h100, 1'b0, BASE, 32'h0, 1'b0, fg, lg);
        step(1'b0, BASE, 1'b1, BASE + 32'h100, 32'hDEAD_BEEF, 1'b0, fg, lg);
        step(1'b1, BASE, 1'b0, BASE, 32'h0, 1'b0, fg, lg);
        step(1'b0, BASE, 1'b0, BASE, 32'h0, 1'b0, fg, lg);

        run_random(400);
        step(1'b0, BASE, 1'b0, BASE, 32'h0, 1'b0, fg, lg);

        // Reset in the cycle whose ack is pending.
        step(1'b0, BASE, 1'b1, BASE + 4 * 9, 32'hCAFE_F00D, 1'b0, fg, lg);
        reset      = 1'b0;
        fetch_req  = 1'b1;
        load_req   = 1'b1;
        load_addr  = BASE + 4 * 9;
        load_data  = 32'h1234_5678;
        fq.delete();
        lq.delete();
        booted     = 1'b0;
        last_fetch = 1'b0;
        fault_m    = 1'b0;
        @(negedge clk);
        check("midreset_stall", {31'b0, stall}, 32'd1);
        check("midreset_fetch_valid", {31'b0, fetch_valid}, 32'd0);
        check("midreset_load_ack", {31'b0, load_ack}, 32'd0);
        check("midreset_addr_fault", {31'b0, addr_fault}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        fetch_req = 1'b0;
        load_req  = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        step(1'b0, BASE, 1'b0, BASE, 32'h0, 1'b1, fg, lg);
        for (int i = 0; i < 5; i++)
            step(1'b1, BASE + 4 * rb[i], 1'b0, BASE, 32'h0, 1'b0, fg, lg);
        repeat (3) step(1'b0, BASE, 1'b0, BASE, 32'h0, 1'b0, fg, lg);
        check("drain_fetch_queue", fq.size(), 32'd0);
        check("drain_load_queue", lq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
